mmu_tlb: RTL and testbench

MMU_TLB -- requirements
Module: mmu_tlb

---
 rtl/mmu_tlb.sv | 157 +++++++++++++++
 tb/tb_mmu_tlb.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_tlb.sv
// mmu_tlb: single-cycle virtual-to-physical address translation with a
// fully-associative TLB, fixed unmapped segments and a saturating miss count.
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   req_valid/req_ready  request handshake; req_vaddr, req_asid request payload
//   resp_valid/resp_ready response handshake; resp_paddr, resp_cache_v,
//                        resp_miss, resp_inv registered result
//   tlb_we, tlb_widx     write one entry; tlb_wvpn, tlb_wpfn, tlb_wasid,
//                        tlb_wg, tlb_wc, tlb_wv entry contents
//   miss_cnt             saturating count of accepted requests that missed
module mmu_tlb #(
  parameter int TLB_NUM = 8,
  parameter int ASID_W  = 8,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [31:0]                req_vaddr,
  input  logic [ASID_W-1:0]          req_asid,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [31:0]                resp_paddr,
  output logic                       resp_cache_v,
  output logic                       resp_miss,
  output logic                       resp_inv,
  input  logic                       tlb_we,
  input  logic [$clog2(TLB_NUM)-1:0] tlb_widx,
  input  logic [19:0]                tlb_wvpn,
  input  logic [19:0]                tlb_wpfn,
  input  logic [ASID_W-1:0]          tlb_wasid,
  input  logic                       tlb_wg,
  input  logic                       tlb_wc,
  input  logic                       tlb_wv,
  output logic [CNT_W-1:0]           miss_cnt
);

  localparam int IDX_W = $clog2(TLB_NUM);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    sat_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
  endfunction

  // TLB storage: only the exists bit needs a reset, the payload is qualified by it
  logic              tlb_e    [TLB_NUM];
  logic [19:0]       tlb_vpn  [TLB_NUM];
  logic [19:0]       tlb_pfn  [TLB_NUM];
  logic [ASID_W-1:0] tlb_asid [TLB_NUM];
  logic              tlb_g    [TLB_NUM];
  logic              tlb_c    [TLB_NUM];
  logic              tlb_v    [TLB_NUM];

  logic              vld_p1;
  logic [31:0]       paddr_p1;
  logic              cache_v_p1;
  logic              miss_p1;
  logic              inv_p1;
  logic [CNT_W-1:0]  miss_cnt_p1;

  logic              accept;
  logic              hit;
  logic [IDX_W-1:0]  hit_idx;
  logic [3:0]        seg;
  logic [31:0]       paddr_p0;
  logic              cache_v_p0;
  logic              miss_p0;
  logic              inv_p0;

  assign req_ready = !vld_p1 || resp_ready;
  assign accept    = req_valid && req_ready;
  assign seg       = req_vaddr[31:28];

  // Stage p0: combinational lookup against the pre-write TLB contents.
  // Scanning downward lets the lowest matching index overwrite higher ones.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = TLB_NUM - 1; i >= 0; i--) begin
      if (tlb_e[i] && (tlb_vpn[i] == req_vaddr[31:12]) &&
          (tlb_g[i] || (tlb_asid[i] == req_asid))) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    paddr_p0   = '0;
    cache_v_p0 = 1'b0;
    miss_p0    = 1'b0;
    inv_p0     = 1'b0;
    if ((seg == 4'h8) || (seg == 4'h9)) begin
      paddr_p0   = {3'b000, req_vaddr[28:0]};
      cache_v_p0 = 1'b1;
    end else if ((seg == 4'hA) || (seg == 4'hB)) begin
      paddr_p0   = {3'b000, req_vaddr[28:0]};
    end else if (hit) begin
      paddr_p0   = {tlb_pfn[hit_idx], req_vaddr[11:0]};
      cache_v_p0 = tlb_v[hit_idx] && tlb_c[hit_idx];
      inv_p0     = !tlb_v[hit_idx];
    end else begin
      miss_p0    = 1'b1;
    end
  end

  // Entry payload write; blocked during reset so a write in that cycle is lost.
  always_ff @(posedge clk) begin
    if (resetn && tlb_we) begin
      tlb_vpn[tlb_widx]  <= tlb_wvpn;
      tlb_pfn[tlb_widx]  <= tlb_wpfn;
      tlb_asid[tlb_widx] <= tlb_wasid;
      tlb_g[tlb_widx]    <= tlb_wg;
      tlb_c[tlb_widx]    <= tlb_wc;
      tlb_v[tlb_widx]    <= tlb_wv;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < TLB_NUM; i++) tlb_e[i] <= 1'b0;
    end else if (tlb_we) begin
      tlb_e[tlb_widx] <= 1'b1;
    end
  end

  // Stage p1: registered response. Result fields only move on an accept, so a
  // stalled response holds and is never re-translated.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_p1      <= 1'b0;
      paddr_p1    <= '0;
      cache_v_p1  <= 1'b0;
      miss_p1     <= 1'b0;
      inv_p1      <= 1'b0;
      miss_cnt_p1 <= '0;
    end else begin
      if (req_ready) vld_p1 <= req_valid;
      if (accept) begin
        paddr_p1   <= paddr_p0;
        cache_v_p1 <= cache_v_p0;
        miss_p1    <= miss_p0;
        inv_p1     <= inv_p0;
        if (miss_p0) miss_cnt_p1 <= sat_inc(miss_cnt_p1);
      end
    end
  end

  assign resp_valid   = vld_p1;
  assign resp_paddr   = paddr_p1;
  assign resp_cache_v = cache_v_p1;
  assign resp_miss    = miss_p1;
  assign resp_inv     = inv_p1;
  assign miss_cnt     = miss_cnt_p1;

endmodule

// File: tb/tb_mmu_tlb.sv
// Testbench for mmu_tlb: directed scenarios followed by randomized traffic,
// all checked against a transaction-level reference model.
module tb_mmu_tlb;

  localparam int N  = 8;
  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_vaddr;
  logic [7:0]  req_asid;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_paddr;
  logic        resp_cache_v;
  logic        resp_miss;
  logic        resp_inv;
  logic        tlb_we;
  logic [2:0]  tlb_widx;
  logic [19:0] tlb_wvpn;
  logic [19:0] tlb_wpfn;
  logic [7:0]  tlb_wasid;
  logic        tlb_wg;
  logic        tlb_wc;
  logic        tlb_wv;
  logic [CW-1:0] miss_cnt;

  mmu_tlb #(.TLB_NUM(N), .ASID_W(8), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vaddr(req_vaddr), .req_asid(req_asid),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_paddr(resp_paddr), .resp_cache_v(resp_cache_v),
    .resp_miss(resp_miss), .resp_inv(resp_inv),
    .tlb_we(tlb_we), .tlb_widx(tlb_widx),
    .tlb_wvpn(tlb_wvpn), .tlb_wpfn(tlb_wpfn), .tlb_wasid(tlb_wasid),
    .tlb_wg(tlb_wg), .tlb_wc(tlb_wc), .tlb_wv(tlb_wv),
    .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  bit          m_e    [N];
  logic [19:0] m_vpn  [N];
  logic [19:0] m_pfn  [N];
  logic [7:0]  m_asid [N];
  bit          m_g    [N];
  bit          m_c    [N];
  bit          m_v    [N];
  bit          m_rv;
  logic [31:0] m_pa;
  bit          m_cv, m_miss, m_inv;
  int          m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void xlate(input logic [31:0] va, input logic [7:0] asid,
                                output logic [31:0] pa, output bit c,
                                output bit mi, output bit iv);
    int seg;
    int found;
    seg   = int'(va / 32'h1000_0000);
    pa    = 0; c = 0; mi = 0; iv = 0;
    found = -1;
    if (seg == 8 || seg == 9 || seg == 10 || seg == 11) begin
      pa = va % 32'h2000_0000;
      c  = (seg == 8 || seg == 9);
    end else begin
      for (int i = 0; i < N; i++) begin
        if (found < 0 && m_e[i] && m_vpn[i] == va[31:12] && (m_g[i] || m_asid[i] == asid))
          found = i;
      end
      if (found < 0) mi = 1;
      else begin
        pa = m_pfn[found] * 32'd4096 + va % 32'd4096;
        c  = m_v[found] && m_c[found];
        iv = !m_v[found];
      end
    end
  endfunction

  // One clock: check handshake before the edge, advance the model, check after.
  task automatic tick();
    bit rdy, in_rst, c, mi, iv;
    logic [31:0] pa;
    @(negedge clk);
    rdy    = !m_rv || resp_ready;
    in_rst = !resetn;
    check("req_ready", 32'(req_ready), 32'(rdy));
    if (in_rst) begin
      for (int i = 0; i < N; i++) m_e[i] = 0;
      m_rv = 0; m_pa = 0; m_cv = 0; m_miss = 0; m_inv = 0; m_cnt = 0;
    end else begin
      if (rdy) begin
        if (req_valid) begin
          xlate(req_vaddr, req_asid, pa, c, mi, iv);
          m_rv = 1; m_pa = pa; m_cv = c; m_miss = mi; m_inv = iv;
          if (mi && m_cnt < (1 << CW) - 1) m_cnt++;
        end else begin
          m_rv = 0;
        end
      end
      if (tlb_we) begin
        m_e[tlb_widx] = 1; m_vpn[tlb_widx] = tlb_wvpn; m_pfn[tlb_widx] = tlb_wpfn;
        m_asid[tlb_widx] = tlb_wasid; m_g[tlb_widx] = tlb_wg;
        m_c[tlb_widx] = tlb_wc; m_v[tlb_widx] = tlb_wv;
      end
    end
    @(posedge clk);
    #1;
    check("resp_valid", 32'(resp_valid), 32'(m_rv));
    check("miss_cnt", 32'(miss_cnt), 32'(m_cnt));
    if (m_rv || in_rst) begin
      check("resp_paddr", resp_paddr, m_pa);
      check("resp_cache_v", 32'(resp_cache_v), 32'(m_cv));
      check("resp_miss", 32'(resp_miss), 32'(m_miss));
      check("resp_inv", 32'(resp_inv), 32'(m_inv));
    end
  endtask

  task automatic req(input logic [31:0] va, input logic [7:0] asid);
    req_valid = 1; req_vaddr = va; req_asid = asid;
  endtask

  task automatic wr(input int idx, input logic [19:0] vpn, input logic [7:0] asid,
                    input logic [19:0] pfn, input bit g, input bit c, input bit v);
    tlb_we = 1; tlb_widx = 3'(idx); tlb_wvpn = vpn; tlb_wasid = asid;
    tlb_wpfn = pfn; tlb_wg = g; tlb_wc = c; tlb_wv = v;
  endtask

  task automatic idle();
    req_valid = 0; tlb_we = 0; resp_ready = 1;
  endtask

  initial begin
    logic [3:0] segs [8];
    logic [3:0] msegs [3];
    segs  = '{4'h0, 4'h4, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hF};
    msegs = '{4'h0, 4'h4, 4'hC};
    for (int i = 0; i < N; i++) begin
      m_e[i] = 0; m_vpn[i] = 0; m_pfn[i] = 0; m_asid[i] = 0;
      m_g[i] = 0; m_c[i] = 0; m_v[i] = 0;
    end
    m_rv = 0; m_pa = 0; m_cv = 0; m_miss = 0; m_inv = 0; m_cnt = 0;
    resetn = 0; req_vaddr = 0; req_asid = 0;
    tlb_widx = 0; tlb_wvpn = 0; tlb_wpfn = 0; tlb_wasid = 0;
    tlb_wg = 0; tlb_wc = 0; tlb_wv = 0;
    idle();
    tick(); tick();
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_paddr", resp_paddr, 32'd0);
    resetn = 1;

    // Unmapped segments
    req(32'h9FC0_1234, 8'd0); tick();
    check("kseg0_paddr", resp_paddr, 32'h1FC0_1234);
    check("kseg0_cache", 32'(resp_cache_v), 32'd1);
    req(32'hB000_0010, 8'd0); tick();
    check("kseg1_paddr", resp_paddr, 32'h1000_0010);
    check("kseg1_cache", 32'(resp_cache_v), 32'd0);

    // ASID-qualified hit and miss
    idle(); wr(3, 20'h00400, 8'd5, 20'h12345, 0, 1, 1); tick();
    tlb_we = 0; req(32'h0040_0ABC, 8'd5); tick();
    check("hit_paddr", resp_paddr, 32'h1234_5ABC);
    check("hit_cache", 32'(resp_cache_v), 32'd1);
    req(32'h0040_0ABC, 8'd6); tick();
    check("asid_miss", 32'(resp_miss), 32'd1);
    check("asid_miss_paddr", resp_paddr, 32'd0);
    check("asid_miss_cnt", 32'(miss_cnt), 32'd1);

    // Priority and invalid entry
    idle(); wr(0, 20'h00400, 8'd0, 20'h11111, 1, 1, 1); tick();
    wr(7, 20'h00400, 8'd0, 20'h77777, 1, 1, 1); tick();
    tlb_we = 0; req(32'h0040_0000, 8'd9); tick();
    check("prio_paddr", resp_paddr, 32'h1111_1000);
    idle(); wr(2, 20'h00500, 8'd0, 20'h22222, 1, 1, 0); tick();
    tlb_we = 0; req(32'h0050_0010, 8'd3); tick();
    check("inv_flag", 32'(resp_inv), 32'd1);
    check("inv_cache", 32'(resp_cache_v), 32'd0);

    // Backpressure hold
    req(32'h8000_0040, 8'd0); tick();
    req(32'h8000_1000, 8'd0); resp_ready = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_paddr", resp_paddr, 32'h0000_0040);
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1; tick();
    check("release_paddr", resp_paddr, 32'h0000_1000);

    // Same-cycle write, then reset mid-stream
    wr(4, 20'h00600, 8'd1, 20'h66666, 0, 1, 1); req(32'h0060_0123, 8'd1); tick();
    check("prewrite_miss", 32'(resp_miss), 32'd1);
    tlb_we = 0; tick();
    check("postwrite_hit", resp_paddr, 32'h6666_6123);
    resetn = 0; tick();
    check("midrst_valid", 32'(resp_valid), 32'd0);
    check("midrst_cnt", 32'(miss_cnt), 32'd0);
    resetn = 1; tick();
    check("postrst_miss", 32'(resp_miss), 32'd1);

    // Counter saturation
    req(32'h0000_0000, 8'd0);
    for (int k = 0; k < 20; k++) tick();
    check("cnt_saturate", 32'(miss_cnt), 32'((1 << CW) - 1));
    resetn = 0; tick(); resetn = 1;

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      resetn     = ($urandom_range(0, 199) != 0);
      req_valid  = ($urandom_range(0, 3) != 0);
      resp_ready = ($urandom_range(0, 3) != 0);
      req_vaddr  = {segs[$urandom_range(0, 7)], 14'd0, 2'($urandom_range(0, 3)), 12'($urandom)};
      req_asid   = 8'($urandom_range(0, 3));
      tlb_we     = ($urandom_range(0, 4) == 0);
      tlb_widx   = 3'($urandom_range(0, N - 1));
      tlb_wvpn   = {msegs[$urandom_range(0, 2)], 14'd0, 2'($urandom_range(0, 3))};
      tlb_wpfn   = 20'($urandom);
      tlb_wasid  = 8'($urandom_range(0, 3));
      tlb_wg     = ($urandom_range(0, 3) == 0);
      tlb_wc     = 1'($urandom);
      tlb_wv     = ($urandom_range(0, 4) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
